// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared types and constants for the Vedic arithmetic unit
package vedic_pkg;
   localparam int DIV_W     = 8;
   localparam int DIV_CNT_W = $clog2(DIV_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: compare-subtract of T against the divisor
module div_step #(
   parameter int W = 8
) (
   input  logic [W:0]   t,
   input  logic [W-1:0] divisor,
   output logic         q_bit,
   output logic [W:0]   r_next
);
   logic [W:0]   d_inv;
   logic [W+1:0] sum;

   // T - D as T + ~D + 1; the carry out is the "no borrow" flag, i.e. T >= D
   always_comb begin
      d_inv  = ~{1'b0, divisor};
      sum    = {1'b0, t} + {1'b0, d_inv} + {{(W+1){1'b0}}, 1'b1};
      q_bit  = sum[W+1];
      r_next = q_bit ? sum[W:0] : t;
   end
endmodule

// File: rtl/vedic_div_16b_8b_seq.sv
// rtl/vedic_div_16b_8b_seq.sv - sequential 2W/W restoring divider, one quotient bit per clock
// Optional macro DIV_OVF_CHECK_EN: early divide-by-zero / overflow detection with err flag.
module vedic_div_16b_8b_seq
   import vedic_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*W-1:0] dividend,
   input  logic [W-1:0]   divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   quotient,
   output logic [W-1:0]   remainder,
   output logic           err
);
   localparam int CW = $clog2(W);

   div_state_t     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W:0]     r_q, r_d;
   logic [W-1:0]   low_q, low_d;
   logic [W-1:0]   dvs_q, dvs_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   rem_q, rem_d;
   logic           err_q, err_d;
   logic [W:0]     t;
   logic           q_bit;
   logic [W:0]     r_next;
   logic           ovf;

`ifdef DIV_OVF_CHECK_EN
   assign ovf = (divisor == '0) || (dividend[2*W-1:W] >= divisor);
`else
   assign ovf = 1'b0;
`endif

   assign t = {r_q[W-1:0], low_q[cnt_q]};

   div_step #(.W(W)) u_step (
      .t       (t),
      .divisor (dvs_q),
      .q_bit   (q_bit),
      .r_next  (r_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= CW'(W-1);
         r_q     <= '0;
         low_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         low_q   <= low_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = ovf ? DONE : CALC;
         CALC:    if (cnt_q == '0) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_comb begin
      cnt_d = cnt_q;
      r_d   = r_q;
      low_d = low_q;
      dvs_d = dvs_q;
      quo_d = quo_q;
      rem_d = rem_q;
      err_d = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               r_d   = {1'b0, dividend[2*W-1:W]};
               low_d = dividend[W-1:0];
               dvs_d = divisor;
               cnt_d = CW'(W-1);
               quo_d = '0;
               err_d = ovf;
               if (ovf) begin
                  quo_d = '1;
                  rem_d = '0;
               end
            end
         end
         CALC: begin
            r_d   = r_next;
            quo_d = {quo_q[W-2:0], q_bit};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               rem_d = r_next[W-1:0];
               cnt_d = CW'(W-1);
            end
         end
         default: ;
      endcase
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign err       = err_q;
endmodule
